pwm_sar_adc: RTL and testbench
==============================

Name: pwm_sar_adc

Overview:
Parametrised PWM-feedback ADC, the next generation of the team's PWM ramp ADC. An internal WIDTH-bit PWM DAC drives pwm_out into an external RC filter. An external comparator reports whether the analog input is above the filtered level. One conversion runs per start request, in either ramp-tracking mode or successive-approximation (SAR) mode, and ends with a one-cycle valid strobe. The block sits between the analog front-end pins and the DDS control logic.

Parameters:
WIDTH, 8, converter resolution and PWM counter width; PWM period = 2^WIDTH clocks
SETTLE_PERIODS, 2, full PWM periods to wait after each duty change before sampling the comparator; range 1..15
SYNC_STAGES, 2, flip-flop stages on cmp_i; minimum 2

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset, asynchronous assert, active-low
cmp_i  in  1  external comparator, asynchronous; 1 = analog input above filtered PWM level
start_i  in  1  conversion request; accepted only in IDLE
mode_i  in  1  0 = ramp-tracking, 1 = SAR; sampled when start_i is accepted
pwm_out  out  1  PWM DAC output
busy_o  out  1  high in every state except IDLE
sample_o  out  WIDTH  last conversion result; holds until the next completed conversion
sample_valid_o  out  1  one-cycle pulse when sample_o updates

Behaviour:
- Reset (async, rst_n_i=0): counter=0, duty=0, state=IDLE, sync chain=0, pwm_out=0, busy_o=0, sample_o=0, sample_valid_o=0.
- PWM: counter cnt increments every clock and wraps 2^WIDTH-1 -> 0.
- pwm_out is registered: pwm_out = (cnt < duty). duty=0 gives constant low; maximum duty gives high for 2^WIDTH-1 of 2^WIDTH clocks.
- Period-end tick pe = (cnt == 2^WIDTH-1).
- duty is written only on pe, so a new duty takes effect from cnt=0. No glitching mid-period.
- Comparator: cmp_i passes through SYNC_STAGES flip-flops to give cmp_s. Decisions use cmp_s sampled on pe only.
- Settle counter: counts pe ticks. A decision is made on the pe that completes SETTLE_PERIODS full periods at the current duty.
- States:
  - IDLE: start_i=1 latches the mode and moves to ARM. start_i in any other state is ignored.
  - ARM: on the next pe, load the initial duty and move to SETTLE. Ramp initial duty = 0. SAR initial duty = 1<<(WIDTH-1), with bit index = WIDTH-1.
  - SETTLE: on the decision pe, act per mode.
- Ramp decision:
  - cmp_s=1 and duty < 2^WIDTH-1: duty <= duty+1, restart settle count.
  - cmp_s=0: result = duty, go to DONE.
  - cmp_s=1 and duty = 2^WIDTH-1: saturate, result = 2^WIDTH-1, go to DONE. No wrap to 0.
- SAR decision at bit index b:
  - cmp_s=0: clear bit b.
  - If b>0: set bit b-1, decrement b, restart settle count.
  - If b=0: result = final duty, go to DONE.
  - Conversion takes exactly WIDTH*SETTLE_PERIODS periods after ARM.
- DONE (one cycle): sample_o <= result, sample_valid_o=1, then IDLE. busy_o is high in DONE. start_i is accepted from the following cycle.
- duty keeps its final value after DONE, so pwm_out keeps driving the last code until the next ARM load.
- Latency: ARM wait is 1..2^WIDTH clocks to the next pe. The SAR total is deterministic beyond that. The ramp total is (code+1)*SETTLE_PERIODS periods.
- Reset mid-conversion: everything aborts to the reset values and no valid pulse is issued.
- Counter arithmetic is unsigned WIDTH-bit. Settle count is 4 bits. Bit index is clog2(WIDTH) bits.

Decomposition:
- Shared package pwm_adc_pkg:
  - state encoding IDLE/ARM/SETTLE/DONE
  - MODE_RAMP=1'b0, MODE_SAR=1'b1
  - settle-count width constant
- Sub-module pwm_dac_core (WIDTH): free-running counter, duty register with pe-gated load, registered pwm_out, pe output.
- The synchroniser is an inline generate loop.

Test Plan:
- Defaults. The bench models cmp_i = (duty_effective < K), sampled with one period of lag. SAR, K=0x5A: valid after 16 periods, sample_o=0x5A, busy_o falls the cycle after valid.
- Ramp, K=3: duty steps 0,1,2,3 with 2 periods each. sample_o=0x03 and valid pulses exactly once.
- Ramp, cmp_i tied 1: duty saturates at 0xFF, sample_o=0xFF, no wrap to 0. SAR with cmp_i tied 1 gives 0xFF; tied 0 gives 0x00.
- PWM shape with duty=0x40: pwm_out high for exactly 64 of 256 clocks. duty=0 gives no high cycle. A duty update occurs only at the cnt 0xFF->0x00 boundary.
- start_i pulsed while busy_o=1 is ignored (single valid). start_i the cycle after valid is accepted. Reset asserted mid-SAR gives all outputs 0 immediately and no valid pulse.
- WIDTH=4, SETTLE_PERIODS=1: SAR, K=9 gives sample_o=4'h9 after 4 periods. A 1-cycle cmp_i glitch away from pe does not affect the result.

Source files
------------

// File: rtl/pwm_adc_pkg.sv
// Shared definitions for the PWM-feedback ADC: FSM encoding, conversion
// mode codes and the settle-counter width.
package pwm_adc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARM    = 2'd1,
      ST_SETTLE = 2'd2,
      ST_DONE   = 2'd3
   } adc_state_t;

   localparam logic MODE_RAMP = 1'b0;
   localparam logic MODE_SAR  = 1'b1;

   // Settle count covers 1..15 full PWM periods per duty step.
   localparam int SETTLE_W = 4;

endpackage

// File: rtl/pwm_dac_core.sv
// PWM DAC core: free-running period counter, duty register that only
// changes at the period boundary, and a registered PWM output.
module pwm_dac_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             duty_load,
   input  logic [WIDTH-1:0] duty_next,
   output logic [WIDTH-1:0] duty,
   output logic             pe,
   output logic             pwm_out
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] cnt;

   assign pe = (cnt == CNT_MAX);

   // Period counter wraps naturally at 2^WIDTH.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) cnt <= '0;
      else          cnt <= cnt + WIDTH'(1);
   end

   // Duty only moves on the last count so every period is a clean single pulse.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)              duty <= '0;
      else if (pe && duty_load)  duty <= duty_next;
   end

   // Registered compare keeps pwm_out free of decode glitches.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) pwm_out <= 1'b0;
      else          pwm_out <= (cnt < duty);
   end

endmodule

// File: rtl/pwm_sar_adc.sv
// PWM-feedback ADC top: comparator synchroniser, conversion FSM (ramp or
// SAR) and the PWM DAC that closes the loop through the external RC filter.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for start_i; mode latched on acceptance
//   ST_ARM    | waiting for the period end to load the initial duty
//   ST_SETTLE | counting settle periods; decides on the last one
//   ST_DONE   | one cycle: sample_valid_o high, result already on sample_o
module pwm_sar_adc
   import pwm_adc_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int SETTLE_PERIODS = 2,
   parameter int SYNC_STAGES    = 2
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             cmp_i,
   input  logic             start_i,
   input  logic             mode_i,
   output logic             pwm_out,
   output logic             busy_o,
   output logic [WIDTH-1:0] sample_o,
   output logic             sample_valid_o
);

   localparam int                  BIT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0]    DUTY_MAX    = '1;
   localparam logic [WIDTH-1:0]    SAR_INIT    = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [BIT_W-1:0]    BIT_TOP     = BIT_W'(WIDTH-1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_PERIODS-1);

   adc_state_t           state;
   logic                 mode;
   logic [BIT_W-1:0]     bit_idx;
   logic [SETTLE_W-1:0]  settle_cnt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 cmp_s;
   logic [WIDTH-1:0]     duty;
   logic                 pe;
   logic                 duty_load;
   logic [WIDTH-1:0]     duty_next;
   logic [WIDTH-1:0]     sar_next;
   logic                 decide;

   genvar g;
   generate
      for (g = 0; g < SYNC_STAGES; g++) begin : g_sync
         if (g == 0) begin : g_first
            // First stage captures the asynchronous comparator.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
               if (!rst_n_i) sync_q[0] <= 1'b0;
               else          sync_q[0] <= cmp_i;
            end
         end else begin : g_next
            // Further stages give metastability time to resolve.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
               if (!rst_n_i) sync_q[g] <= 1'b0;
               else          sync_q[g] <= sync_q[g-1];
            end
         end
      end
   endgenerate

   assign cmp_s  = sync_q[SYNC_STAGES-1];
   assign decide = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);

   // Next duty request; the DAC core only honours it on the period end.
   always_comb begin
      duty_load = 1'b0;
      duty_next = duty;
      sar_next  = duty;
      if (!cmp_s)          sar_next[bit_idx]              = 1'b0;
      if (bit_idx != '0)   sar_next[bit_idx - BIT_W'(1)]  = 1'b1;
      case (state)
         ST_ARM: begin
            duty_load = 1'b1;
            duty_next = (mode == MODE_SAR) ? SAR_INIT : '0;
         end
         ST_SETTLE: begin
            if (decide) begin
               if (mode == MODE_RAMP) begin
                  if (cmp_s && (duty != DUTY_MAX)) begin
                     duty_load = 1'b1;
                     duty_next = duty + WIDTH'(1);
                  end
               end else begin
                  duty_load = 1'b1;
                  duty_next = sar_next;
               end
            end
         end
         default: ;
      endcase
   end

   // Conversion sequencer; all status outputs are registered here.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state          <= ST_IDLE;
         mode           <= MODE_RAMP;
         bit_idx        <= '0;
         settle_cnt     <= '0;
         busy_o         <= 1'b0;
         sample_o       <= '0;
         sample_valid_o <= 1'b0;
      end else begin
         sample_valid_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  mode   <= mode_i;
                  busy_o <= 1'b1;
                  state  <= ST_ARM;
               end
            end
            ST_ARM: begin
               if (pe) begin
                  settle_cnt <= '0;
                  bit_idx    <= BIT_TOP;
                  state      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (pe) begin
                  if (settle_cnt != SETTLE_LAST) begin
                     settle_cnt <= settle_cnt + SETTLE_W'(1);
                  end else begin
                     settle_cnt <= '0;
                     if (mode == MODE_RAMP) begin
                        // Stop on the first code at or above the input, or saturate.
                        if (!cmp_s || (duty == DUTY_MAX)) begin
                           sample_o       <= duty;
                           sample_valid_o <= 1'b1;
                           state          <= ST_DONE;
                        end
                     end else if (bit_idx != '0) begin
                        bit_idx <= bit_idx - BIT_W'(1);
                     end else begin
                        sample_o       <= sar_next;
                        sample_valid_o <= 1'b1;
                        state          <= ST_DONE;
                     end
                  end
               end
            end
            ST_DONE: begin
               busy_o <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   pwm_dac_core #(
      .WIDTH (WIDTH)
   ) u_dac (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .duty_load (duty_load),
      .duty_next (duty_next),
      .duty      (duty),
      .pe        (pe),
      .pwm_out   (pwm_out)
   );

endmodule

// File: tb/tb_pwm_sar_adc.sv
// Directed bench for pwm_sar_adc: a default 8-bit instance and a 4-bit,
// single-settle-period instance. The comparator model sets cmp = (level < T)
// where the level is read off pwm_out at count T-1 of each period (high there
// exactly when duty > T-1). Ramp stops on the first code >= T, so it uses
// T = K; SAR returns the largest code below T, so it uses T = K+1.
module tb_pwm_sar_adc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       cmp8, start8, mode8, pwm8, busy8, v8;
   logic [7:0] s8;
   logic       cmp4, start4, mode4, pwm4, busy4, v4;
   logic [3:0] s4;

   pwm_sar_adc dut (
      .clk_i(clk), .rst_n_i(rst_n), .cmp_i(cmp8), .start_i(start8), .mode_i(mode8),
      .pwm_out(pwm8), .busy_o(busy8), .sample_o(s8), .sample_valid_o(v8)
   );

   pwm_sar_adc #(.WIDTH(4), .SETTLE_PERIODS(1), .SYNC_STAGES(2)) dut4 (
      .clk_i(clk), .rst_n_i(rst_n), .cmp_i(cmp4), .start_i(start4), .mode_i(mode4),
      .pwm_out(pwm4), .busy_o(busy4), .sample_o(s4), .sample_valid_o(v4)
   );

   int n_vec = 0;
   int n_err = 0;

   // comparator model controls: cm = 0 tied low, 1 tied high, 2 level model
   int         t8 = 0, t4 = 0;
   logic [1:0] cm8 = 2'd0, cm4 = 2'd0;
   logic [7:0] tc8;
   logic [3:0] tc4;
   int         acc8;
   int         hist8 [8];
   logic       pp8, pp4;
   int         rises8 = 0, rises4 = 0;

   // Comparator / filter model and PWM shape monitor.
   initial begin
      tc8 = '0; tc4 = '0; cmp8 = 1'b0; cmp4 = 1'b0;
      acc8 = 0; pp8 = 1'b0; pp4 = 1'b0;
      foreach (hist8[i]) hist8[i] = -1;
      forever begin
         @(posedge clk);
         if (rst_n) begin tc8 = tc8 + 8'd1; tc4 = tc4 + 4'd1; end
         else begin tc8 = '0; tc4 = '0; end
         @(negedge clk);
         case (cm8)
            2'd0:    cmp8 = 1'b0;
            2'd1:    cmp8 = 1'b1;
            default: if (int'(tc8) == t8) cmp8 = ~pwm8;
         endcase
         case (cm4)
            2'd0:    cmp4 = 1'b0;
            2'd1:    cmp4 = 1'b1;
            default: if (int'(tc4) == t4) cmp4 = ~pwm4;
         endcase
         // pwm must only rise on the first sample of a period
         if (pwm8 && !pp8 && tc8 != 8'd1) rises8++;
         if (pwm4 && !pp4 && tc4 != 4'd1) rises4++;
         pp8 = pwm8;
         pp4 = pwm4;
         if (tc8 == 8'd1) acc8 = int'(pwm8);
         else             acc8 = acc8 + int'(pwm8);
         if (tc8 == 8'd0) begin
            for (int i = 7; i > 0; i--) hist8[i] = hist8[i-1];
            hist8[0] = acc8;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
      n_vec++;
      assert (obs >= lo && obs <= hi) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic wait_valid(input bit sel4, input int maxc, output int cyc, output bit got);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < maxc) begin
         tick();
         cyc++;
         if (sel4 ? v4 : v8) got = 1'b1;
      end
   endtask

   task automatic cnt_high(input bit sel4, input int n, output int h);
      h = 0;
      repeat (n) begin
         tick();
         h += sel4 ? int'(pwm4) : int'(pwm8);
      end
   endtask

   task automatic go8(input logic m);
      mode8  = m;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
   endtask

   int cyc, h, nv;
   bit got;

   initial begin
      rst_n = 1'b0; start8 = 1'b0; mode8 = 1'b0; start4 = 1'b0; mode4 = 1'b0;
      repeat (3) tick();
      chk("rst_pwm",    32'(pwm8),  0);
      chk("rst_busy",   32'(busy8), 0);
      chk("rst_sample", 32'(s8),    0);
      chk("rst_valid",  32'(v8),    0);
      @(negedge clk);
      rst_n = 1'b1;

      cnt_high(1'b0, 256, h);
      chk("duty0_high_count", h, 0);

      // SAR K=0x5A with an ignored start pulse (ramp mode) mid-conversion
      cm8 = 2'd2; t8 = 32'h5B;
      go8(1'b1);
      chk("sar5a_busy_on_start", 32'(busy8), 1);
      cyc = 0; got = 1'b0;
      while (!got && cyc < 18*256) begin
         tick();
         cyc++;
         if (cyc == 2000) begin start8 = 1'b1; mode8 = 1'b0; end
         if (cyc == 2001) start8 = 1'b0;
         if (v8) got = 1'b1;
      end
      chk("sar5a_done", 32'(got), 1);
      chk_rng("sar5a_latency", cyc, 16*256+1, 17*256);
      chk("sar5a_cnt_at_valid", 32'(tc8), 0);
      chk("sar5a_sample", 32'(s8), 32'h5A);
      chk("sar5a_busy_at_valid", 32'(busy8), 1);
      tick();
      chk("sar5a_valid_one_cycle", 32'(v8), 0);
      chk("sar5a_busy_fall", 32'(busy8), 0);

      // ramp K=3, started the cycle after the previous valid
      t8 = 3;
      go8(1'b0);
      chk("ramp_accept_after_valid", 32'(busy8), 1);
      wait_valid(1'b0, 10*256, cyc, got);
      chk("ramp3_done", 32'(got), 1);
      chk_rng("ramp3_latency", cyc, 8*256+1, 9*256);
      chk("ramp3_sample", 32'(s8), 32'h03);
      for (int i = 0; i < 8; i++)
         chk($sformatf("ramp3_step%0d", i), 32'(hist8[i]), 32'(3 - i/2));
      nv = 0;
      repeat (300) begin tick(); if (v8) nv++; end
      chk("ramp3_single_valid", nv, 0);
      chk("ramp3_idle_busy", 32'(busy8), 0);
      cnt_high(1'b0, 256, h);
      chk("ramp3_duty_held", h, 3);

      // SAR with comparator tied high / low
      cm8 = 2'd1;
      go8(1'b1);
      wait_valid(1'b0, 18*256, cyc, got);
      chk("sar_hi_done", 32'(got), 1);
      chk("sar_hi_sample", 32'(s8), 32'hFF);
      tick();
      cm8 = 2'd0;
      go8(1'b1);
      wait_valid(1'b0, 18*256, cyc, got);
      chk("sar_lo_done", 32'(got), 1);
      chk("sar_lo_sample", 32'(s8), 32'h00);
      tick();

      // SAR K=0x40 then check the held PWM shape
      cm8 = 2'd2; t8 = 32'h41;
      go8(1'b1);
      wait_valid(1'b0, 18*256, cyc, got);
      chk("sar40_done", 32'(got), 1);
      chk("sar40_sample", 32'(s8), 32'h40);
      tick();
      cnt_high(1'b0, 256, h);
      chk("duty40_high_count", h, 64);

      // reset in the middle of a SAR conversion
      t8 = 32'h5B;
      go8(1'b1);
      repeat (1000) tick();
      chk("midrst_busy_before", 32'(busy8), 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_pwm",    32'(pwm8),  0);
      chk("midrst_busy",   32'(busy8), 0);
      chk("midrst_sample", 32'(s8),    0);
      chk("midrst_valid",  32'(v8),    0);
      repeat (3) tick();
      @(negedge clk);
      rst_n = 1'b1;
      nv = 0;
      repeat (5000) begin tick(); if (v8) nv++; end
      chk("midrst_no_valid", nv, 0);
      chk("midrst_idle", 32'(busy8), 0);
      cnt_high(1'b0, 256, h);
      chk("midrst_duty0", h, 0);

      // 4-bit, 1 settle period: SAR K=9 with comparator glitches away from pe
      cm4 = 2'd2; t4 = 10;
      mode4 = 1'b1; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      cyc = 0; got = 1'b0;
      while (!got && cyc < 100) begin
         tick();
         cyc++;
         if (tc4 == 4'd4 || tc4 == 4'd5) cmp4 = ~cmp4;
         if (v4) got = 1'b1;
      end
      chk("w4_sar9_done", 32'(got), 1);
      chk_rng("w4_sar9_latency", cyc, 4*16+1, 5*16);
      chk("w4_sar9_cnt_at_valid", 32'(tc4), 0);
      chk("w4_sar9_sample", 32'(s4), 32'h9);
      tick();

      // 4-bit ramp with comparator tied high saturates without wrapping
      cm4 = 2'd1;
      mode4 = 1'b0; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      wait_valid(1'b1, 300, cyc, got);
      chk("w4_ramp_sat_done", 32'(got), 1);
      chk_rng("w4_ramp_sat_latency", cyc, 16*16+1, 17*16);
      chk("w4_ramp_sat_sample", 32'(s4), 32'hF);
      tick();
      cnt_high(1'b1, 16, h);
      chk("w4_ramp_sat_duty_held", h, 15);

      chk("pwm_rise_only_at_period_start", rises8, 0);
      chk("w4_pwm_rise_only_at_period_start", rises4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
